// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback block.
// Optional forwarding ports are enabled with `define RF_WB_FWD_EN.
package rf_wb_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  function automatic logic [NREG-1:0] rd_onehot(
    input logic [REG_AW-1:0] rd
  );
    logic [NREG-1:0] oh;
    oh     = '0;
    oh[rd] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/rf_writeback_fifo.sv
// Pending LSU result queue with per-entry invalidate-by-rd.
// Optional forwarding in the top is enabled with `define RF_WB_FWD_EN.
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  wb_entry_t         push_entry,
  input  logic              pop,
  output wb_entry_t         head,
  input  logic              inv_en,
  input  logic [REG_AW-1:0] inv_rd,
  output logic              full,
  output logic              empty,
  output logic [NREG-1:0]   mask
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign head  = mem[rd_ptr];

  // Popped slots drop vld so vld alone marks a live pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (inv_en && mem[i].rd == inv_rd) mem[i].vld <= 1'b0;
      end
      if (pop) begin
        mem[rd_ptr].vld <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i].vld) mask = mask | rd_onehot(mem[i].rd);
    end
    mask[0] = 1'b0;
  end
endmodule

// File: rtl/rf_writeback.sv
// Merges ALU and LSU results into one register-file write per cycle.
// `define RF_WB_FWD_EN adds write-then-read forwarding ports.
module rf_writeback
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              rf_en,
  output logic [REG_AW-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_wdata,
`ifdef RF_WB_FWD_EN
  input  logic [REG_AW-1:0] fwd_rs1,
  input  logic [REG_AW-1:0] fwd_rs2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [XLEN-1:0]   fwd_data1,
  output logic [XLEN-1:0]   fwd_data2,
`endif
  output logic [NREG-1:0]   pending_mask
);
  logic            full;
  logic            empty;
  logic [NREG-1:0] fifo_mask;
  wb_entry_t       head;
  wb_entry_t       lsu_entry;
  logic            lsu_xfer;
  logic            alu_sel;
  logic            pop;
  logic            byp;
  logic            push;

  logic              en_d;
  logic [REG_AW-1:0] rd_d;
  logic [XLEN-1:0]   wd_d;

  assign lsu_ready = !full;
  assign lsu_xfer  = lsu_valid && lsu_ready;
  assign alu_sel   = alu_valid && (alu_rd != '0);
  assign pop       = !alu_sel && !empty;
  assign byp       = !alu_sel && empty && lsu_xfer &&
                     (lsu_rd != '0);
  assign push      = lsu_xfer && (lsu_rd != '0) && !byp;
  assign lsu_entry = '{vld: 1'b1, rd: lsu_rd, data: lsu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (lsu_entry),
    .pop        (pop),
    .head       (head),
    .inv_en     (alu_sel),
    .inv_rd     (alu_rd),
    .full       (full),
    .empty      (empty),
    .mask       (fifo_mask)
  );

  // Idle and invalidated pops keep rd/wdata; only rf_en drops.
  always_comb begin
    en_d = 1'b0;
    rd_d = rf_rd;
    wd_d = rf_wdata;
    unique case (1'b1)
      alu_sel: begin
        en_d = 1'b1;
        rd_d = alu_rd;
        wd_d = alu_data;
      end
      pop: begin
        if (head.vld) begin
          en_d = 1'b1;
          rd_d = head.rd;
          wd_d = head.data;
        end
      end
      byp: begin
        en_d = 1'b1;
        rd_d = lsu_rd;
        wd_d = lsu_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_en    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      rf_en    <= en_d;
      rf_rd    <= rd_d;
      rf_wdata <= wd_d;
    end
  end

  always_comb begin
    pending_mask = fifo_mask;
    if (rf_en) pending_mask = pending_mask | rd_onehot(rf_rd);
    pending_mask[0] = 1'b0;
  end

`ifdef RF_WB_FWD_EN
  assign fwd_hit1  = rf_en && (rf_rd == fwd_rs1) && (fwd_rs1 != '0);
  assign fwd_hit2  = rf_en && (rf_rd == fwd_rs2) && (fwd_rs2 != '0);
  assign fwd_data1 = rf_wdata;
  assign fwd_data2 = rf_wdata;
`endif
endmodule

// File: tb/tb_rf_writeback.sv
// Directed self-checking bench for rf_writeback (DEPTH=4).
// Forwarding checks build only with `define RF_WB_FWD_EN.
module tb_rf_writeback;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        rf_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] pending_mask;
`ifdef RF_WB_FWD_EN
  logic [4:0]  fwd_rs1;
  logic [4:0]  fwd_rs2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int lsu_idx;
  logic xfer;
  logic [31:0] xreg [32];

  always #5 clk = ~clk;

  rf_writeback #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .rf_en        (rf_en),
    .rf_rd        (rf_rd),
    .rf_wdata     (rf_wdata),
`ifdef RF_WB_FWD_EN
    .fwd_rs1      (fwd_rs1),
    .fwd_rs2      (fwd_rs2),
    .fwd_hit1     (fwd_hit1),
    .fwd_hit2     (fwd_hit2),
    .fwd_data1    (fwd_data1),
    .fwd_data2    (fwd_data2),
`endif
    .pending_mask (pending_mask)
  );

  // Register file stand-in: commits on the edge after rf_* is shown.
  always @(posedge clk) begin
    if (rf_en) xreg[rf_rd] <= rf_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    lsu_valid = 1'b0;
    lsu_rd    = '0;
    lsu_data  = '0;
`ifdef RF_WB_FWD_EN
    fwd_rs1   = '0;
    fwd_rs2   = '0;
`endif
    for (int i = 0; i < 32; i++) xreg[i] = '0;
    tick();
    tick();
    chk("rst_en", 32'(rf_en), 32'd0);
    chk("rst_rd", 32'(rf_rd), 32'd0);
    chk("rst_wd", rf_wdata, 32'd0);
    chk("rst_rdy", 32'(lsu_ready), 32'd1);
    chk("rst_mask", pending_mask, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1) single ALU write
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    chk("t1_en", 32'(rf_en), 32'd1);
    chk("t1_rd", 32'(rf_rd), 32'd5);
    chk("t1_wd", rf_wdata, 32'hDEADBEEF);
    chk("t1_mask", pending_mask, 32'h0000_0020);
    tick();
    chk("t1_en_off", 32'(rf_en), 32'd0);
    chk("t1_rd_hold", 32'(rf_rd), 32'd5);

    // 2) LSU bypass with empty FIFO
    lsu_valid = 1'b1;
    lsu_rd    = 5'd7;
    lsu_data  = 32'h11;
    chk("t2_rdy", 32'(lsu_ready), 32'd1);
    chk("t2_mask_pre", 32'(pending_mask[7]), 32'd0);
    tick();
    lsu_valid = 1'b0;
    chk("t2_en", 32'(rf_en), 32'd1);
    chk("t2_rd", 32'(rf_rd), 32'd7);
    chk("t2_wd", rf_wdata, 32'h11);
    chk("t2_mask", pending_mask, 32'h0000_0080);
    tick();
    chk("t2_en_off", 32'(rf_en), 32'd0);
    chk("t2_mask_post", pending_mask, 32'd0);

    // 3) ALU busy 6 cycles while LSU streams rd1..6
    lsu_idx = 1;
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1;
      alu_rd    = 5'(10 + i);
      alu_data  = 32'h100 + 32'(i);
      lsu_valid = 1'b1;
      lsu_rd    = 5'(lsu_idx);
      lsu_data  = 32'h200 + 32'(lsu_idx);
      chk("t3_rdy", 32'(lsu_ready), (i < 4) ? 32'd1 : 32'd0);
      xfer = lsu_valid && lsu_ready;
      tick();
      if (xfer) lsu_idx++;
      chk("t3_alu_rd", 32'(rf_rd), 32'(10 + i));
    end
    chk("t3_accepted", 32'(lsu_idx), 32'd5);
    chk("t3_mask_full", pending_mask, 32'h0000_801E);
    alu_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      lsu_valid = (lsu_idx <= 6);
      lsu_rd    = 5'(lsu_idx);
      lsu_data  = 32'h200 + 32'(lsu_idx);
      xfer = lsu_valid && lsu_ready;
      tick();
      if (xfer) lsu_idx++;
      chk("t3_drain_en", 32'(rf_en), 32'd1);
      chk("t3_drain_rd", 32'(rf_rd), 32'(k));
      chk("t3_drain_wd", rf_wdata, 32'h200 + 32'(k));
    end
    lsu_valid = 1'b0;
    tick();
    chk("t3_idle", 32'(rf_en), 32'd0);
    chk("t3_all_in", 32'(lsu_idx), 32'd7);
    chk("t3_x4", xreg[4], 32'h204);

    // 4) WAW: queued load to x3 superseded by ALU write
    alu_valid = 1'b1;
    alu_rd    = 5'd10;
    alu_data  = 32'h1;
    lsu_valid = 1'b1;
    lsu_rd    = 5'd3;
    lsu_data  = 32'h33;
    tick();
    lsu_valid = 1'b0;
    alu_rd    = 5'd3;
    alu_data  = 32'hA;
    chk("t4_mask_q", pending_mask, 32'h0000_0408);
    tick();
    alu_valid = 1'b0;
    chk("t4_alu_rd", 32'(rf_rd), 32'd3);
    chk("t4_alu_wd", rf_wdata, 32'hA);
    chk("t4_mask_out", pending_mask, 32'h0000_0008);
    tick();
    chk("t4_inv_en", 32'(rf_en), 32'd0);
    chk("t4_mask_clr", pending_mask, 32'd0);
    tick();
    chk("t4_x3", xreg[3], 32'hA);

    // 5) rd==0 discard, then reset with 3 queued
    alu_valid = 1'b1;
    alu_rd    = 5'd0;
    alu_data  = 32'h99;
    lsu_valid = 1'b1;
    lsu_rd    = 5'd0;
    lsu_data  = 32'h77;
    chk("t5_rdy", 32'(lsu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    chk("t5_en0", 32'(rf_en), 32'd0);
    chk("t5_mask0", pending_mask, 32'd0);
    tick();
    chk("t5_nopush", 32'(rf_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1;
      alu_rd    = 5'(20 + i);
      alu_data  = 32'h300 + 32'(i);
      lsu_valid = 1'b1;
      lsu_rd    = 5'(1 + i);
      lsu_data  = 32'h400 + 32'(i);
      tick();
    end
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    chk("t5_mask_q", pending_mask, 32'h0040_000E);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_en", 32'(rf_en), 32'd0);
    chk("t5_rst_rd", 32'(rf_rd), 32'd0);
    chk("t5_rst_wd", rf_wdata, 32'd0);
    chk("t5_rst_rdy", 32'(lsu_ready), 32'd1);
    chk("t5_rst_mask", pending_mask, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_post_en", 32'(rf_en), 32'd0);
    chk("t5_post_mask", pending_mask, 32'd0);

`ifdef RF_WB_FWD_EN
    // 6) forwarding from the output register
    alu_valid = 1'b1;
    alu_rd    = 5'd9;
    alu_data  = 32'h55;
    tick();
    alu_valid = 1'b0;
    fwd_rs1   = 5'd9;
    fwd_rs2   = 5'd0;
    #1;
    chk("t6_hit1", 32'(fwd_hit1), 32'd1);
    chk("t6_data1", fwd_data1, 32'h55);
    chk("t6_hit2", 32'(fwd_hit2), 32'd0);
    fwd_rs1 = 5'd8;
    fwd_rs2 = 5'd9;
    #1;
    chk("t6_miss1", 32'(fwd_hit1), 32'd0);
    chk("t6_hit2b", 32'(fwd_hit2), 32'd1);
    chk("t6_data2", fwd_data2, 32'h55);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
